// File: rtl/uart_cmd_arbiter_pkg.sv
// Shared encodings for the RS-422 command-link arbiter: FSM states, reply flag
// and the frame delimiters the link layer already uses.
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        SEND     = 2'd2,
        WAIT_ACK = 2'd3
    } arb_state_t;

    // A remote reply echoes the command byte with this bit set.
    localparam logic [7:0] ACK_FLAG = 8'h80;

    localparam logic [7:0] FRAME_SYNC0 = 8'hAA;
    localparam logic [7:0] FRAME_SYNC1 = 8'h55;
    localparam logic [7:0] FRAME_END   = 8'hEF;

    function automatic logic [7:0] ack_of(input logic [7:0] cmd);
        return cmd | ACK_FLAG;
    endfunction

endpackage

// File: rtl/uart_cmd_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr,
// wrapping from N_REQ-1 back to 0 (ptr itself is checked last).
module rr_pick
    import uart_cmd_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [2:0]       ptr,
    output logic [2:0]       grant,
    output logic             found
);

    always_comb begin
        grant = ptr;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (!found && req[j] && (j == ((int'(ptr) + k) % N_REQ))) begin
                    found = 1'b1;
                    grant = 3'(j);
                end
            end
        end
    end

endmodule

// File: rtl/uart_cmd_arbiter.sv
// Round-robin sharing of the framed command transmit channel among N_REQ requesters.
// Define CMD_ACK_EN to add reply matching, ack timeout and retry with req_err reporting.
module uart_cmd_arbiter
    import uart_cmd_pkg::*;
#(
    parameter int          N_REQ       = 4,
    parameter logic [31:0] ACK_TIMEOUT = 32'd50000,
    parameter int          MAX_RETRY   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [8*N_REQ-1:0]    req_cmd,
    input  logic [32*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]      req_done,
    output logic [N_REQ-1:0]      req_err,
    output logic                  command_tx_ready,
    output logic [7:0]            command_tx,
    output logic [31:0]           data_field_tx,
    input  logic                  command_tx_status,
    input  logic                  command_tx_over,
    input  logic                  command_rx_ready,
    input  logic [7:0]            command_rx,
    output logic                  busy,
    output logic [2:0]            grant_id
);

    arb_state_t  state;
    arb_state_t  next_state;
    logic [2:0]  ptr;
    logic [2:0]  pick_idx;
    logic        pick_found;
    logic [7:0]  pick_cmd;
    logic [31:0] pick_data;
    logic [7:0]  snap_cmd;
    logic [31:0] snap_data;
    logic        load_grant;
    logic        done_set;
    logic        pulse_active;

`ifdef CMD_ACK_EN
    logic [31:0] tmo_cnt;
    logic [7:0]  retry_cnt;
    logic        reply_match;
    logic        timed_out;
    logic        retry_ok;
    logic        retry_inc;
    logic        err_set;

    assign reply_match = command_rx_ready && (command_rx == ack_of(snap_cmd));
    assign timed_out   = (tmo_cnt == (ACK_TIMEOUT - 32'd1));
    assign retry_ok    = (retry_cnt < 8'(MAX_RETRY));
`endif

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        pick_cmd  = '0;
        pick_data = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (pick_idx == 3'(j)) begin
                pick_cmd  = req_cmd[8*j +: 8];
                pick_data = req_data[32*j +: 32];
            end
        end
    end

    // The cycle a done/err pulse is visible gives the requester time to drop req_valid.
    assign pulse_active = (|req_done) || (|req_err);

    always_comb begin
        next_state = state;
        load_grant = 1'b0;
        done_set   = 1'b0;
`ifdef CMD_ACK_EN
        retry_inc  = 1'b0;
        err_set    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!pulse_active && pick_found) begin
                    load_grant = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                if (command_tx_status) begin
                    next_state = SEND;
                end
            end
            SEND: begin
                if (command_tx_over) begin
`ifdef CMD_ACK_EN
                    next_state = WAIT_ACK;
`else
                    next_state = IDLE;
                    done_set   = 1'b1;
`endif
                end
            end
            WAIT_ACK: begin
`ifdef CMD_ACK_EN
                // A reply arriving on the timeout cycle still counts as success.
                if (reply_match) begin
                    done_set   = 1'b1;
                    next_state = IDLE;
                end else if (timed_out) begin
                    if (retry_ok) begin
                        retry_inc  = 1'b1;
                        next_state = ISSUE;
                    end else begin
                        err_set    = 1'b1;
                        next_state = IDLE;
                    end
                end
`else
                next_state = IDLE;
`endif
            end
            default: next_state = IDLE;
        endcase
    end

    // The snapshot only loads on a grant, so requester changes during service are ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            snap_cmd  <= '0;
            snap_data <= '0;
            req_done  <= '0;
        end else begin
            state    <= next_state;
            req_done <= done_set ? (N_REQ'(1) << ptr) : '0;
            if (load_grant) begin
                ptr       <= pick_idx;
                snap_cmd  <= pick_cmd;
                snap_data <= pick_data;
            end
        end
    end

`ifdef CMD_ACK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_cnt   <= '0;
            retry_cnt <= '0;
            req_err   <= '0;
        end else begin
            req_err <= err_set ? (N_REQ'(1) << ptr) : '0;
            if (load_grant) begin
                retry_cnt <= '0;
            end else if (retry_inc) begin
                retry_cnt <= retry_cnt + 8'd1;
            end
            if (state == SEND && command_tx_over) begin
                tmo_cnt <= '0;
            end else if (state == WAIT_ACK) begin
                tmo_cnt <= tmo_cnt + 32'd1;
            end
        end
    end
`else
    logic unused_ack;
    assign unused_ack = ^{command_rx_ready, command_rx, ACK_TIMEOUT, 32'(MAX_RETRY)};
    assign req_err    = '0;
`endif

    // The pointer always holds the most recent grant, so it doubles as grant_id.
    assign grant_id         = ptr;
    assign busy             = (state != IDLE);
    assign command_tx_ready = (state == ISSUE);
    assign command_tx       = snap_cmd;
    assign data_field_tx    = snap_data;

endmodule

// File: tb/tb_uart_cmd_arbiter.sv
// Self-checking bench for uart_cmd_arbiter: table-driven grant sequence plus
// hand-written ack/retry/reset sequences, with a scoreboard of expected frames.
module tb_uart_cmd_arbiter;

    localparam int          N       = 4;
    localparam logic [31:0] TMO     = 32'd20;
    localparam int          RETRIES = 2;
`ifdef CMD_ACK_EN
    localparam bit ACK_BUILD = 1'b1;
`else
    localparam bit ACK_BUILD = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [8*N-1:0]  req_cmd;
    logic [32*N-1:0] req_data;
    logic [N-1:0]    req_done;
    logic [N-1:0]    req_err;
    logic            command_tx_ready;
    logic [7:0]      command_tx;
    logic [31:0]     data_field_tx;
    logic            command_tx_status;
    logic            command_tx_over;
    logic            command_rx_ready;
    logic [7:0]      command_rx;
    logic            busy;
    logic [2:0]      grant_id;

    always #5 clk = ~clk;

    uart_cmd_arbiter #(.N_REQ(N), .ACK_TIMEOUT(TMO), .MAX_RETRY(RETRIES)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid         (req_valid),
        .req_cmd           (req_cmd),
        .req_data          (req_data),
        .req_done          (req_done),
        .req_err           (req_err),
        .command_tx_ready  (command_tx_ready),
        .command_tx        (command_tx),
        .data_field_tx     (data_field_tx),
        .command_tx_status (command_tx_status),
        .command_tx_over   (command_tx_over),
        .command_rx_ready  (command_rx_ready),
        .command_rx        (command_rx),
        .busy              (busy),
        .grant_id          (grant_id)
    );

    typedef struct {
        logic [2:0]  grant;
        logic [7:0]  cmd;
        logic [31:0] data;
    } frame_t;

    typedef struct {
        logic [3:0] mask;
        int         grant;
    } vec_t;

    frame_t      sb[$];
    vec_t        vecs[10];
    logic [7:0]  cmds[4];
    logic [31:0] datas[4];
    int          total = 0;
    int          bad = 0;
    int          n;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic pushExpect(input int g);
        frame_t f;
        f.grant = 3'(g);
        f.cmd   = cmds[g];
        f.data  = datas[g];
        sb.push_back(f);
    endtask

    task automatic applyStimulus(input logic [3:0] mask, input int g);
        req_valid = mask;
        if (g >= 0) pushExpect(g);
    endtask

    // Acts as the link: waits for a pending frame, checks it, then transmits it.
    task automatic serveFrame(input int expLatency, input bit doOver);
        int     waited;
        frame_t e;
        waited = 0;
        while (!command_tx_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("grant_latency", 64'(waited), 64'(expLatency));
        if (!command_tx_ready) return;
        if (sb.size() == 0) begin
            checkOutput("sb_underflow", 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        checkOutput("grant_id", 64'(grant_id), 64'(e.grant));
        checkOutput("command_tx", 64'(command_tx), 64'(e.cmd));
        checkOutput("data_field_tx", 64'(data_field_tx), 64'(e.data));
        checkOutput("busy_in_issue", 64'(busy), 64'd1);
        command_tx_status = 1'b1;
        @(negedge clk);
        checkOutput("ready_drop", 64'(command_tx_ready), 64'd0);
        req_cmd  = ~req_cmd;
        req_data = ~req_data;
        repeat (2) @(negedge clk);
        checkOutput("snap_cmd_hold", 64'(command_tx), 64'(e.cmd));
        checkOutput("snap_data_hold", 64'(data_field_tx), 64'(e.data));
        req_cmd  = ~req_cmd;
        req_data = ~req_data;
        if (doOver) begin
            command_tx_status = 1'b0;
            command_tx_over   = 1'b1;
            @(negedge clk);
            command_tx_over   = 1'b0;
        end
    endtask

    task automatic sendReply(input logic [7:0] b);
        command_rx       = b;
        command_rx_ready = 1'b1;
        @(negedge clk);
        command_rx_ready = 1'b0;
        command_rx       = 8'h00;
    endtask

    task automatic finishFrame(input int idx);
        if (ACK_BUILD) sendReply(cmds[idx] | 8'h80);
    endtask

    task automatic expectDone(input int idx, input logic [3:0] nextMask, input int nextGrant);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        checkOutput("done_pulse", 64'(req_done), 64'(oh));
        checkOutput("no_err", 64'(req_err), 64'd0);
        checkOutput("idle_on_done", 64'(busy), 64'd0);
        applyStimulus(nextMask, nextGrant);
        @(negedge clk);
        checkOutput("done_width", 64'(req_done), 64'd0);
        checkOutput("skip_cycle_ready", 64'(command_tx_ready), 64'd0);
    endtask

    task automatic waitEvent(output int cnt);
        cnt = 0;
        while (!(command_tx_ready || (req_done != '0) || (req_err != '0)) && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_ready"}, 64'(command_tx_ready), 64'd0);
        checkOutput({tag, "_cmd"}, 64'(command_tx), 64'd0);
        checkOutput({tag, "_data"}, 64'(data_field_tx), 64'd0);
        checkOutput({tag, "_grant"}, 64'(grant_id), 64'd0);
        checkOutput({tag, "_done"}, 64'(req_done), 64'd0);
        checkOutput({tag, "_err"}, 64'(req_err), 64'd0);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        cmds[0] = 8'h12; datas[0] = 32'hDEADBEEF;
        cmds[1] = 8'h21; datas[1] = 32'h01234567;
        cmds[2] = 8'h34; datas[2] = 32'hA5A55A5A;
        cmds[3] = 8'h47; datas[3] = 32'hCAFEF00D;
        for (int i = 0; i < N; i++) begin
            req_cmd[8*i +: 8]   = cmds[i];
            req_data[32*i +: 32] = datas[i];
        end
        // Grant order follows the pointer left by the previous grant.
        vecs[0] = '{4'b1000, 3};
        vecs[1] = '{4'b1111, 0};
        vecs[2] = '{4'b1111, 1};
        vecs[3] = '{4'b1111, 2};
        vecs[4] = '{4'b1111, 3};
        vecs[5] = '{4'b1111, 0};
        vecs[6] = '{4'b1001, 3};
        vecs[7] = '{4'b1001, 0};
        vecs[8] = '{4'b0110, 1};
        vecs[9] = '{4'b0100, 2};

        req_valid         = '0;
        command_tx_status = 1'b0;
        command_tx_over   = 1'b0;
        command_rx_ready  = 1'b0;
        command_rx        = 8'h00;
        rst_n             = 1'b0;
        repeat (3) @(negedge clk);
        checkResetState("reset");
        rst_n = 1'b1;

        applyStimulus(4'b0001, 0);
        serveFrame(1, 1'b1);
        finishFrame(0);
        expectDone(0, vecs[0].mask, vecs[0].grant);

        for (int i = 0; i < 10; i++) begin
            serveFrame(1, 1'b1);
            finishFrame(vecs[i].grant);
            if (i < 9) expectDone(vecs[i].grant, vecs[i+1].mask, vecs[i+1].grant);
            else       expectDone(vecs[i].grant, 4'b0000, -1);
        end

`ifdef CMD_ACK_EN
        applyStimulus(4'b0010, 1);
        pushExpect(1);
        pushExpect(1);
        serveFrame(1, 1'b1);
        for (int r = 0; r < RETRIES; r++) begin
            waitEvent(n);
            checkOutput("retry_gap", 64'(n), 64'(TMO));
            checkOutput("no_err_before_last", 64'(req_err), 64'd0);
            serveFrame(0, 1'b1);
        end
        waitEvent(n);
        checkOutput("err_gap", 64'(n), 64'(TMO));
        checkOutput("err_pulse", 64'(req_err), 64'b0010);
        checkOutput("err_no_done", 64'(req_done), 64'd0);
        checkOutput("err_no_fourth_frame", 64'(command_tx_ready), 64'd0);
        applyStimulus(4'b0000, -1);
        @(negedge clk);
        checkOutput("err_width", 64'(req_err), 64'd0);
        checkOutput("idle_after_err", 64'(busy), 64'd0);

        applyStimulus(4'b0001, 0);
        pushExpect(0);
        serveFrame(1, 1'b1);
        sendReply(8'h93);
        waitEvent(n);
        checkOutput("wrong_reply_ignored", 64'(n), 64'(TMO - 1));
        checkOutput("wrong_reply_no_done", 64'(req_done), 64'd0);
        serveFrame(0, 1'b1);
        repeat (int'(TMO) - 1) @(negedge clk);
        sendReply(8'h92);
        checkOutput("match_at_timeout_done", 64'(req_done), 64'b0001);
        checkOutput("match_at_timeout_no_err", 64'(req_err), 64'd0);
        checkOutput("match_at_timeout_no_retry", 64'(command_tx_ready), 64'd0);
        applyStimulus(4'b0000, -1);
        @(negedge clk);
`endif

        applyStimulus(4'b1000, 3);
        serveFrame(1, ACK_BUILD);
        checkOutput("busy_before_reset", 64'(busy), 64'd1);
        command_tx_status = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        checkResetState("midreset");
        rst_n = 1'b1;
        applyStimulus(4'b0100, 2);
        serveFrame(1, 1'b1);
        finishFrame(2);
        expectDone(2, 4'b0000, -1);

        checkOutput("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_cmd_arbiter.md
# uart_cmd_arbiter

Shares the single framed-command transmit channel of the RS-422 command link among N_REQ requesters. Requesters are served round-robin. The arbiter drives the link's command_tx_ready / command_tx / data_field_tx handshake and waits for frame completion. With acknowledge checking compiled in, it also matches the remote reply, retries on timeout, and reports success or failure per requester.

## Interface
- N_REQ, 4: number of requesters, 2..8.
- ACK_TIMEOUT, 32'd50000: clk cycles to wait for a reply after command_tx_over.
- MAX_RETRY, 2: re-sends after the first attempt before declaring failure.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  N_REQ  per-requester request; held high with stable cmd/data until req_done or req_err.
- req_cmd  in  8*N_REQ  command byte; requester i occupies bits [8i+7:8i].
- req_data  in  32*N_REQ  data field; requester i occupies bits [32i+31:32i].
- req_done  out  N_REQ  one-cycle pulse: request completed.
- req_err  out  N_REQ  one-cycle pulse: request failed (retries exhausted).
- command_tx_ready  out  1  to link: new frame pending.
- command_tx  out  8  to link: command byte.
- data_field_tx  out  32  to link: data field.
- command_tx_status  in  1  from link: frame transmitting.
- command_tx_over  in  1  from link: one-cycle pulse, frame finished.
- command_rx_ready  in  1  from link: one-cycle pulse, valid frame received.
- command_rx  in  8  from link: received command byte.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  3  index of the current or most recent grant.

## Operation
- Reset values: all outputs 0; state IDLE; round-robin pointer 0; retry count 0; timeout counter 0.
- **IDLE**
  - Arbitration is skipped in any cycle where any bit of req_done or req_err is high. This gives the requester one cycle to drop req_valid.
  - Otherwise the arbiter picks the first set bit of req_valid, searching from pointer+1 with wrap-around (index N_REQ-1 wraps to 0).
  - On a pick: snapshot that requester's cmd/data into internal registers, set grant_id, set pointer to the picked index, clear retry count, go to ISSUE.
- **ISSUE**
  - command_tx_ready=1; command_tx and data_field_tx carry the snapshot.
  - On command_tx_status=1: drive command_tx_ready=0 and go to SEND.
- **SEND**
  - Wait for command_tx_over.
  - On command_tx_over: go to WAIT_ACK and clear the timeout counter. Without CMD_ACK_EN, go to IDLE and pulse req_done[grant] instead.
- **WAIT_ACK**
  - The timeout counter increments each cycle.
  - A reply matches when command_rx_ready=1 and command_rx equals the snapshot cmd with bit 7 set (snapshot cmd | 8'h80). On a match: pulse req_done[grant], go to IDLE.
  - Non-matching replies are ignored.
  - Timeout is counter == ACK_TIMEOUT-1. On timeout:
    - if retry count < MAX_RETRY: increment retry count, go to ISSUE;
    - else: pulse req_err[grant], go to IDLE.
  - If a match and the timeout occur in the same cycle, the match wins.
- The snapshot is not updated while busy. Changes on req_cmd/req_data during service are ignored.
- If req_valid[grant] drops while the request is in service, the frame still completes and req_done/req_err still pulse.
- A reset mid-frame returns the arbiter to IDLE in the next cycle. Any link frame already started completes independently.

## Timing
- Grant latency: req_valid high in IDLE → state ISSUE and command_tx_ready=1 on the next clk edge (1 cycle).
- command_tx_ready stays asserted until the first cycle command_tx_status is observed high, then deasserts on the following edge.
- req_done/req_err are registered and last exactly 1 cycle. They are asserted during the first IDLE cycle; no grant is made in that cycle.
- Back-to-back service: minimum 2 cycles from req_done to the next command_tx_ready.
- Timeout arithmetic: 32-bit counter; no reply within ACK_TIMEOUT cycles after command_tx_over triggers a retry.

## Configuration
- **CMD_ACK_EN defined:** WAIT_ACK state, timeout counter and retry logic are present, as described above.
- **CMD_ACK_EN not defined:** SEND goes straight to IDLE on command_tx_over with req_done; req_err is tied to 0; command_rx and command_rx_ready are unused; ACK_TIMEOUT and MAX_RETRY have no effect.

## Structure
- Shared package `uart_cmd_pkg` holds:
  - state encoding: IDLE=0, ISSUE=1, SEND=2, WAIT_ACK=3;
  - ACK_FLAG = 8'h80;
  - the frame constants already used by the link: AA, 55, EF.
- One sub-module: `rr_pick`, a combinational round-robin priority picker with inputs req vector and pointer and outputs grant index and found flag.

## Test plan
- **Single request:** req_valid=4'b0001, cmd 8'h12, data 32'hDEADBEEF → command_tx_ready 1 cycle later with those values; after over plus reply 8'h92, req_done=4'b0001 for 1 cycle.
- **Fairness:** req_valid=4'b1111 held after each done → grant order 0,1,2,3,0; with pointer=3, req_valid=4'b1001 → grant 0.
- **Timeout/retry:** MAX_RETRY=2, no reply → exactly 3 frames are sent, each ACK_TIMEOUT cycles after the previous over, then req_err pulses.
- **Reply handling:** reply 8'h93 for cmd 8'h12 → ignored, timeout proceeds. Correct reply in the same cycle as the timeout → req_done, no retry.
- **Reset mid-operation:** rst_n low during WAIT_ACK → next cycle all outputs 0 and state IDLE; a subsequent request is served normally.
- **Build without CMD_ACK_EN:** req_done pulses on the cycle after command_tx_over; req_err is always 0.
